temp_avrg_datapath: RTL and testbench

TEMP_AVRG_DATAPATH -- requirements
Module: temp_avrg_datapath

---
 rtl/avrg_pkg.sv | 20 ++
 rtl/avrg_div.sv | 94 +++++++++
 rtl/temp_avrg_datapath.sv | 104 ++++++++++
 tb/tb_temp_avrg_datapath.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/avrg_pkg.sv
// Shared defaults, accumulator width helper and divider state encoding
// for the temperature averaging datapath.
package avrg_pkg;

  localparam int TICKS_PER_SEC_DEF = 50_000_000;
  localparam int SAMPLES_DEF       = 60;
  localparam int TEMP_W_DEF        = 8;

  // Width that holds the sum of a full window of maximum-valued samples.
  function automatic int acc_width(input int samples, input int temp_w);
    return $clog2(samples * ((1 << temp_w) - 1) + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/avrg_div.sv
// Sequential restoring divider by the constant SAMPLES: one quotient bit
// per cycle, ACC_W cycles in BUSY, then a single DONE cycle.
module avrg_div
  import avrg_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int ACC_W   = acc_width(SAMPLES_DEF, TEMP_W_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  output logic [ACC_W-1:0] quotient,
  output logic             done
);

  localparam int             CNT_W    = $clog2(ACC_W + 1);
  localparam logic [ACC_W:0] DIVISOR  = (ACC_W + 1)'(SAMPLES);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(ACC_W - 1);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [ACC_W-1:0] dvd_reg;
  logic [ACC_W-1:0] quo_reg;
  logic [ACC_W-1:0] rem_reg;

  logic [ACC_W:0]   rem_shift;
  logic             fits;
  logic [ACC_W-1:0] rem_next;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  // The remainder is always below SAMPLES, so ACC_W bits hold it.
  always_comb begin
    rem_shift = {rem_reg, dvd_reg[ACC_W-1]};
    fits      = (rem_shift >= DIVISOR);
    rem_next  = fits ? ACC_W'(rem_shift - DIVISOR) : rem_shift[ACC_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; clear wins over everything, start only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt_reg == LAST_IT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Datapath: latch dividend on start, then shift/subtract while BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      dvd_reg <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
      dvd_reg <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            quo_reg <= '0;
            rem_reg <= '0;
            cnt_reg <= '0;
          end
        end
        BUSY: begin
          dvd_reg <= dvd_reg << 1;
          quo_reg <= (quo_reg << 1) | ACC_W'(fits);
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign quotient = quo_reg;
  assign done     = (state_reg == DONE);

endmodule

// File: rtl/temp_avrg_datapath.sv
// Temperature averaging datapath: seconds prescaler, per-second sample
// accumulation over a window of SAMPLES seconds, and a sequential divide
// that produces the window average.
module temp_avrg_datapath
  import avrg_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int SAMPLES       = SAMPLES_DEF,
  parameter int TEMP_W        = TEMP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_timer,
  input  logic              rst_timer,
  input  logic              rst_segundos,
  input  logic              en_avrg,
  input  logic              rst_avrg,
  input  logic [TEMP_W-1:0] temp,
  output logic              second,
  output logic              minute,
  output logic [TEMP_W-1:0] avrg,
  output logic              avrg_valid
);

  localparam int ACC_W = acc_width(SAMPLES, TEMP_W);
  localparam int PRE_W = $clog2(TICKS_PER_SEC);
  localparam int SEC_W = $clog2(SAMPLES + 1);

  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] PRE_PEN  = PRE_W'(TICKS_PER_SEC - 2);
  localparam logic [SEC_W-1:0] SEC_FULL = SEC_W'(SAMPLES);

  logic [PRE_W-1:0] presc_reg;
  logic [SEC_W-1:0] sec_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             tick;
  logic [ACC_W-1:0] quotient;
  logic             div_done;

  // A tick is the single edge where the prescaler steps onto its terminal
  // value; sitting at the terminal value never produces another one.
  assign tick = en_timer && !rst_segundos && (presc_reg == PRE_PEN);

  // Sub-second prescaler, saturating at its terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   presc_reg <= '0;
    else if (rst_segundos)                      presc_reg <= '0;
    else if (en_timer && presc_reg < PRE_TERM)  presc_reg <= presc_reg + PRE_W'(1);
  end

  // Seconds counter and accumulator; a clear drops any coincident sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_reg <= '0;
      acc_reg <= '0;
    end else if (rst_timer) begin
      sec_reg <= '0;
      acc_reg <= '0;
    end else if (tick && sec_reg != SEC_FULL) begin
      sec_reg <= sec_reg + SEC_W'(1);
      acc_reg <= acc_reg + ACC_W'(temp);
    end
  end

  avrg_div #(
    .SAMPLES (SAMPLES),
    .ACC_W   (ACC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .clear    (rst_avrg),
    .start    (en_avrg),
    .dividend (acc_reg),
    .quotient (quotient),
    .done     (div_done)
  );

  // The average never exceeds the largest sample, so the low TEMP_W
  // quotient bits carry the whole result.
  generate
    if (ACC_W > TEMP_W) begin : g_quo_hi
      logic quo_hi_unused;
      assign quo_hi_unused = ^quotient[ACC_W-1:TEMP_W];
    end
  endgenerate

  // Average output register and its one-cycle update strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avrg       <= '0;
      avrg_valid <= 1'b0;
    end else if (rst_avrg) begin
      avrg       <= '0;
      avrg_valid <= 1'b0;
    end else begin
      avrg_valid <= div_done;
      if (div_done) avrg <= quotient[TEMP_W-1:0];
    end
  end

  assign second = (presc_reg == PRE_TERM);
  assign minute = (sec_reg == SEC_FULL);

endmodule

// File: tb/tb_temp_avrg_datapath.sv
// Bench for temp_avrg_datapath with a 4-tick second and 4-sample window.
module tb_temp_avrg_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_timer = 1'b0;
  logic       rst_timer = 1'b0;
  logic       rst_segundos = 1'b0;
  logic       en_avrg = 1'b0;
  logic       rst_avrg = 1'b0;
  logic [7:0] temp = 8'd0;
  logic       second;
  logic       minute;
  logic [7:0] avrg;
  logic       avrg_valid;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];

  temp_avrg_datapath #(
    .TICKS_PER_SEC (4),
    .SAMPLES       (4),
    .TEMP_W        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_timer     (en_timer),
    .rst_timer    (rst_timer),
    .rst_segundos (rst_segundos),
    .en_avrg      (en_avrg),
    .rst_avrg     (rst_avrg),
    .temp         (temp),
    .second       (second),
    .minute       (minute),
    .avrg         (avrg),
    .avrg_valid   (avrg_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every avrg_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && avrg_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got pulse avrg=%0d expected no pulse", avrg);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("result avrg=%0d expected=%0d", avrg, e);
        check("avrg_result", int'(avrg), e);
      end
    end
  end

  // Restart the prescaler, then let it run to its tick with sample t.
  task automatic tick_sample(input logic [7:0] t, input logic rt);
    temp = t;
    rst_segundos = 1'b1;
    @(posedge clk); #1 rst_segundos = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("pre_tick_second", int'(second), 0);
    rst_timer = rt;
    @(posedge clk); #1 rst_timer = 1'b0;
    check("tick_second", int'(second), 1);
  endtask

  task automatic pulse_rst_timer();
    rst_timer = 1'b1;
    @(posedge clk); #1 rst_timer = 1'b0;
  endtask

  // Launch a divide and check the strobe lands exactly ACC_W+1 edges later.
  task automatic run_divide(input int exp);
    exp_q.push_back(exp);
    en_avrg = 1'b1;
    @(posedge clk); #1 en_avrg = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("valid_early", int'(avrg_valid), 0);
    @(posedge clk); #1 check("valid_on_time", int'(avrg_valid), 1);
    @(posedge clk); #1 check("valid_single", int'(avrg_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    en_timer = 1'b1;
    temp = 8'd10;
    repeat (2) @(posedge clk);
    #1;
    check("rst_second", int'(second), 0);
    check("rst_minute", int'(minute), 0);
    check("rst_avrg", int'(avrg), 0);
    check("rst_valid", int'(avrg_valid), 0);
    rst = 1'b1;

    // First tick 3 enabled cycles after release, then second holds
    repeat (2) @(posedge clk);
    #1 check("first_pre_tick", int'(second), 0);
    @(posedge clk); #1 check("first_tick", int'(second), 1);
    @(posedge clk); #1 check("second_hold", int'(second), 1);
    check("minute_after_one", int'(minute), 0);

    // Fill the window: 10+20+30+41 = 101
    tick_sample(8'd20, 1'b0);
    tick_sample(8'd30, 1'b0);
    check("minute_after_three", int'(minute), 0);
    tick_sample(8'd41, 1'b0);
    check("minute_full", int'(minute), 1);
    // Fifth tick is ignored by the saturated counter
    tick_sample(8'd200, 1'b0);
    check("minute_saturated", int'(minute), 1);

    // Divide 101/4 = 25; rst_timer and a BUSY en_avrg must not disturb it
    exp_q.push_back(25);
    en_avrg = 1'b1;
    @(posedge clk); #1 en_avrg = 1'b0;
    rst_timer = 1'b1;
    @(posedge clk); #1 rst_timer = 1'b0;
    en_avrg = 1'b1;
    @(posedge clk); #1 en_avrg = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("valid_early", int'(avrg_valid), 0);
    @(posedge clk); #1 check("valid_on_time", int'(avrg_valid), 1);
    check("avrg_25", int'(avrg), 25);
    @(posedge clk); #1 check("valid_single", int'(avrg_valid), 0);
    check("minute_cleared", int'(minute), 0);

    // All zeros still pulses
    for (int i = 0; i < 4; i++) tick_sample(8'd0, 1'b0);
    run_divide(0);

    // All 255
    pulse_rst_timer();
    for (int i = 0; i < 4; i++) tick_sample(8'd255, 1'b0);
    run_divide(255);
    check("avrg_255", int'(avrg), 255);

    // Abort 5 cycles into BUSY: no strobe, avrg cleared
    en_avrg = 1'b1;
    @(posedge clk); #1 en_avrg = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_avrg = 1'b1;
    @(posedge clk); #1 rst_avrg = 1'b0;
    check("abort_avrg", int'(avrg), 0);
    repeat (15) @(posedge clk);
    #1 check("abort_no_valid", int'(avrg_valid), 0);
    check("abort_avrg_stays", int'(avrg), 0);

    // rst_timer coincident with a tick drops that sample
    tick_sample(8'd200, 1'b1);
    check("coincident_minute", int'(minute), 0);
    for (int i = 0; i < 3; i++) tick_sample(8'd8, 1'b0);
    check("dropped_minute_three", int'(minute), 0);
    tick_sample(8'd8, 1'b0);
    check("dropped_minute_four", int'(minute), 1);
    run_divide(8);

    // Asynchronous reset mid-window and mid-divide
    en_avrg = 1'b1;
    @(posedge clk); #1 en_avrg = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_second", int'(second), 0);
    check("async_minute", int'(minute), 0);
    check("async_avrg", int'(avrg), 0);
    check("async_valid", int'(avrg_valid), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("post_rst_pre_tick", int'(second), 0);
    @(posedge clk); #1 check("post_rst_tick", int'(second), 1);
    repeat (15) @(posedge clk);
    #1 check("post_rst_no_valid", int'(avrg_valid), 0);
    check("post_rst_avrg", int'(avrg), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
